// File: rtl/arbitro_rr.sv
// Round-robin class arbiter: moves one head word per cycle from a bank of
// FWFT input FIFOs into the output FIFO selected by the word's class field.
module arbitro_rr #(
    parameter int NUM_IN     = 4,
    parameter int NUM_OUT    = 4,
    parameter int CLASS_W    = 2,
    parameter int DATA_W     = 10,
    parameter int BLOCK_MODE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_IN-1:0]          empty,
    input  logic [NUM_IN*DATA_W-1:0]   data_in,
    input  logic [NUM_OUT-1:0]         almost_full,
    output logic [NUM_IN-1:0]          pop,
    output logic [NUM_OUT-1:0]         push,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(NUM_IN)-1:0]  grant,
    output logic                       idle
);

    localparam int GW = $clog2(NUM_IN);

    logic [NUM_IN-1:0]   pop_q, pop_d;
    logic [NUM_OUT-1:0]  push_q, push_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [GW-1:0]       grant_q, grant_d;

    logic [CLASS_W-1:0]  class_s [NUM_IN];
    logic [NUM_IN-1:0]   elig_s;
    logic                found_s;
    logic [GW-1:0]       win_s;
    logic [GW:0]         sum_s;
    logic [GW:0]         idx_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [CLASS_W-1:0]  sel_class_s;

    // Mode 0 stalls every class on any almost_full; mode 1 only the affected class.
    function automatic logic class_blocked(input logic [CLASS_W-1:0] c,
                                           input logic [NUM_OUT-1:0] af);
        if (BLOCK_MODE == 0) begin
            return |af;
        end else begin
            return af[c];
        end
    endfunction

    // Per-input class extraction and eligibility (skip the input popped last cycle).
    always_comb begin
        elig_s = {NUM_IN{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            class_s[i] = data_in[i*DATA_W + DATA_W-1 -: CLASS_W];
            elig_s[i]  = ~empty[i] & ~pop_q[i] & ~class_blocked(class_s[i], almost_full);
        end
    end

    // Cyclic search starting just after the last served input.
    always_comb begin
        found_s = 1'b0;
        win_s   = grant_q;
        sum_s   = {(GW+1){1'b0}};
        idx_s   = {(GW+1){1'b0}};
        for (int k = 1; k <= NUM_IN; k++) begin
            sum_s = {1'b0, grant_q} + (GW+1)'(k);
            if (sum_s >= (GW+1)'(NUM_IN)) begin
                idx_s = sum_s - (GW+1)'(NUM_IN);
            end else begin
                idx_s = sum_s;
            end
            if (!found_s && elig_s[idx_s[GW-1:0]]) begin
                found_s = 1'b1;
                win_s   = idx_s[GW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state for the registered pop/push/data/grant outputs.
    always_comb begin
        pop_d      = {NUM_IN{1'b0}};
        push_d     = {NUM_OUT{1'b0}};
        data_d     = data_q;
        grant_d    = grant_q;
        sel_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            if (win_s == GW'(i)) begin
                sel_data_s = data_in[i*DATA_W +: DATA_W];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
        sel_class_s = sel_data_s[DATA_W-1 -: CLASS_W];
        if (found_s) begin
            pop_d   = {{(NUM_IN-1){1'b0}}, 1'b1} << win_s;
            push_d  = {{(NUM_OUT-1){1'b0}}, 1'b1} << sel_class_s;
            data_d  = sel_data_s;
            grant_d = win_s;
        end else begin
            pop_d  = {NUM_IN{1'b0}};
            push_d = {NUM_OUT{1'b0}};
        end
    end

    // State registers; reset points grant at the last input so input 0 goes first.
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_q   <= {NUM_IN{1'b0}};
            push_q  <= {NUM_OUT{1'b0}};
            data_q  <= {DATA_W{1'b0}};
            grant_q <= GW'(NUM_IN-1);
        end else begin
            pop_q   <= pop_d;
            push_q  <= push_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign data_out = data_q;
    assign grant    = grant_q;
    assign idle     = (&empty) & ~(|pop_q) & ~(|push_q);

endmodule
